// File: rtl/aes_round_core.sv
// aes_round_core: iterative AES-128 encryption core, one full round per clock.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous active-high reset
//   start        : request to encrypt plain_in (ignored unless idle)
//   plain_in     : 128-bit plaintext, byte i at [8i+7:8i]
//   expanded_key : 11 round keys, round key r at [128r+127:128r]
//   busy         : high while rounds are being computed
//   done         : one-cycle pulse, cipher_text valid from this cycle
//   cipher_text  : last completed ciphertext, held until the next one
//
// State element s[row][col] is byte 4*col+row (column-major, byte 0 in LSBs).
//
// Build option: define AES_CORE_KEY_LATCH_EN to capture round keys 1..10 at
// the accepting start edge, so expanded_key may change while busy. Without
// it, expanded_key must stay stable from start until done.

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. The inverse is x^254, built from x^2 * x^4 * ... * x^128.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = '0;
    aa  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] pow_sq;
  logic [7:0] inv;

  always_comb begin
    pow_sq = in_byte;
    inv    = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      pow_sq = gf_mul(pow_sq, pow_sq);
      inv    = gf_mul(inv, pow_sq);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_round_core (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [127:0]   plain_in,
  input  logic [1407:0]  expanded_key,
  output logic           busy,
  output logic           done,
  output logic [127:0]   cipher_text
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROUND  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]   fsm_q, fsm_d;
  logic [3:0]   ctr_q, ctr_d;
  logic [127:0] state_q, state_d;
  logic [127:0] cipher_q, cipher_d;

  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] round_key;
  logic [7:0]   a0, a1, a2, a3;

`ifdef AES_CORE_KEY_LATCH_EN
  logic [1279:0] key_q, key_d;
`endif

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (state_q[8*i +: 8]),
      .out_byte (sub_bytes[8*i +: 8])
    );
  end

  // Round key for the round currently indexed by the counter (1..10).
  always_comb begin
    round_key = '0;
    for (int unsigned r = 1; r <= 10; r++) begin
`ifdef AES_CORE_KEY_LATCH_EN
      if (ctr_q == r[3:0]) round_key = key_q[128*(r-1) +: 128];
`else
      if (ctr_q == r[3:0]) round_key = expanded_key[128*r +: 128];
`endif
    end
  end

  // ShiftRows: s'[row][col] = s[row][(col+row) mod 4]; then MixColumns.
  always_comb begin
    shifted = '0;
    mixed   = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shifted[8*(4*c+r) +: 8] = sub_bytes[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = shifted[8*(4*c+0) +: 8];
      a1 = shifted[8*(4*c+1) +: 8];
      a2 = shifted[8*(4*c+2) +: 8];
      a3 = shifted[8*(4*c+3) +: 8];
      mixed[8*(4*c+0) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mixed[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mixed[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mixed[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    ctr_d    = ctr_q;
    state_d  = state_q;
    cipher_d = cipher_q;
`ifdef AES_CORE_KEY_LATCH_EN
    key_d    = key_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = plain_in ^ expanded_key[127:0];
          ctr_d   = 4'd1;
          fsm_d   = ROUND;
`ifdef AES_CORE_KEY_LATCH_EN
          key_d   = expanded_key[1407:128];
`endif
        end
      end
      ROUND: begin
        if (ctr_q == 4'd10) begin
          // Final round skips MixColumns; counter parks at 0 so it never passes 10.
          state_d  = shifted ^ round_key;
          cipher_d = shifted ^ round_key;
          ctr_d    = '0;
          fsm_d    = FINISH;
        end else begin
          state_d = mixed ^ round_key;
          ctr_d   = ctr_q + 4'd1;
        end
      end
      FINISH:  fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= IDLE;
      ctr_q    <= '0;
      state_q  <= '0;
      cipher_q <= '0;
`ifdef AES_CORE_KEY_LATCH_EN
      key_q    <= '0;
`endif
    end else begin
      fsm_q    <= fsm_d;
      ctr_q    <= ctr_d;
      state_q  <= state_d;
      cipher_q <= cipher_d;
`ifdef AES_CORE_KEY_LATCH_EN
      key_q    <= key_d;
`endif
    end
  end

  assign busy        = (fsm_q == ROUND);
  assign done        = (fsm_q == FINISH);
  assign cipher_text = cipher_q;

endmodule

// File: tb/tb_aes_round_core.sv
// Scoreboard bench for aes_round_core: stimulus pushes expected ciphertext
// and completion cycle; a negedge monitor checks busy/done/cipher_text.
module tb_aes_round_core;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [127:0]  plain_in;
  logic [1407:0] expanded_key;
  logic          busy;
  logic          done;
  logic [127:0]  cipher_text;

  aes_round_core dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .plain_in     (plain_in),
    .expanded_key (expanded_key),
    .busy         (busy),
    .done         (done),
    .cipher_text  (cipher_text)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] FIPS_PT  = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] FIPS_CT  = 128'h5AC5B47080B7CDD830047B6AD8E0C469;

  typedef struct {
    logic [127:0] ct;
    int unsigned  cyc;
  } exp_t;

  exp_t         sb[$];
  int unsigned  cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [127:0] exp_ct = '0;
  logic [7:0]   sbox_t[256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 0) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box table generated by walking generator 3 and its inverse together.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [1407:0] model_expand(input logic [127:0] key);
    logic [7:0]    w[44][4];
    logic [7:0]    t[4];
    logic [7:0]    rcon = 8'h01;
    logic [1407:0] ek;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) w[i][k] = key[8*(4*i+k) +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int k = 0; k < 4; k++) t[k] = w[i-1][k];
      if (i % 4 == 0) begin
        for (int k = 0; k < 4; k++) t[k] = sbox_t[w[i-1][(k+1)%4]];
        t[0] = t[0] ^ rcon;
        rcon = gmul(rcon, 8'h02);
      end
      for (int k = 0; k < 4; k++) w[i][k] = w[i-4][k] ^ t[k];
    end
    for (int i = 0; i < 44; i++)
      for (int k = 0; k < 4; k++) ek[32*i+8*k +: 8] = w[i][k];
    return ek;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [1407:0] ek);
    logic [7:0]   st[16];
    logic [7:0]   t[16];
    logic [7:0]   a[4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) st[i] = pt[8*i +: 8] ^ ek[8*i +: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[st[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) st[4*c+row] = t[4*((c+row)%4)+row];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) a[row] = st[4*c+row];
          for (int row = 0; row < 4; row++)
            st[4*c+row] = gmul(a[row], 8'h02) ^ gmul(a[(row+1)%4], 8'h03)
                        ^ a[(row+2)%4] ^ a[(row+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ ek[128*rnd+8*i +: 8];
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = st[i];
    return res;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    logic exp_done;
    forever begin
      @(negedge clk);
      exp_done = (sb.size() > 0) && (sb[0].cyc == cyc);
      check("busy", {127'd0, busy}, {127'd0, (sb.size() > 0) && !exp_done});
      check("done", {127'd0, done}, {127'd0, exp_done});
      if (exp_done) begin
        e = sb.pop_front();
        exp_ct = e.ct;
      end
      check("cipher_text", cipher_text, exp_ct);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [127:0] pt, input logic [1407:0] ek, input logic [127:0] expv);
    @(negedge clk);
    plain_in     = pt;
    expanded_key = ek;
    start        = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{ct: expv, cyc: cyc + 10});
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: %0d results still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [1407:0] fips_ek;
    logic [1407:0] ek;
    logic [127:0]  key;
    logic [127:0]  pt[4];

    build_sbox();
    fips_ek      = model_expand(FIPS_KEY);
    rst          = 1'b1;
    start        = 1'b0;
    plain_in     = '0;
    expanded_key = '0;
    #1;
    check("reset busy", {127'd0, busy}, '0);
    check("reset done", {127'd0, done}, '0);
    check("reset cipher_text", cipher_text, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Known-answer vector
    issue(FIPS_PT, fips_ek, FIPS_CT);
    wait_idle();

    // Randomized single encryptions
    for (int n = 0; n < 8; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt[0] = {$urandom, $urandom, $urandom, $urandom};
      if (n == 0) pt[0] = '0;
      if (n == 1) begin key = '1; pt[0] = '1; end
      ek = model_expand(key);
      issue(pt[0], ek, model_encrypt(pt[0], ek));
      wait_idle();
    end

    // Back-to-back with start held high: accepts every 12 cycles
    key = {$urandom, $urandom, $urandom, $urandom};
    ek  = model_expand(key);
    for (int k = 0; k < 4; k++) pt[k] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    expanded_key = ek;
    plain_in     = pt[0];
    start        = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      sb.push_back('{ct: model_encrypt(pt[k], ek), cyc: cyc + 10});
      if (k < 3) begin
        plain_in = pt[k+1];
        repeat (11) @(posedge clk);
      end else begin
        start = 1'b0;
      end
    end
    wait_idle();

    // Start pulses during rounds 3 and 9 must be ignored
    issue(FIPS_PT, fips_ek, FIPS_CT);
    repeat (2) @(posedge clk);
    #1;
    start    = 1'b1;
    plain_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Asynchronous reset during round 5 aborts without done
    issue(FIPS_PT, fips_ek, FIPS_CT);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    exp_ct = '0;
    #1;
    check("abort busy", {127'd0, busy}, '0);
    check("abort done", {127'd0, done}, '0);
    check("abort cipher_text", cipher_text, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    issue(FIPS_PT, fips_ek, FIPS_CT);
    wait_idle();

`ifdef AES_CORE_KEY_LATCH_EN
    // Round keys captured at start; zeroing the input key bus must not matter
    issue(FIPS_PT, fips_ek, FIPS_CT);
    @(negedge clk);
    expanded_key = '0;
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
